moore_seq_generator: RTL and testbench
======================================

Name: moore_seq_generator

Overview:
- Serial pattern transmitter. It is the sending end of the 12-bit Moore sequence detector link: it drives `check` of the detector.
- On a start request it emits a fixed 12-bit pattern MSB-first, one bit per clk, repeated a programmable number of times.
- A one-cycle idle-high gap separates consecutive frames, so the detector's final (output) state can return to its initial state between frames.
- Registered Moore outputs throughout; used standalone and in the detector's self-check bench.

Parameters:
- PATTERN_W, 12, pattern length in bits (min 2).
- PATTERN, 12'b011100011011, bit sequence; bit PATTERN_W-1 is sent first.
- REPEAT_W, 4, width of the repeat-count input.
- IDX_W, 4, width of bit_index; must satisfy 2**IDX_W >= PATTERN_W.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous reset, active-high (asserted = 1), despite the name.
- start  input  1  request; sampled only in IDLE.
- repeat_count  input  REPEAT_W  number of frames to send; sampled with start; 0 is treated as 1.
- abort  input  1  cancel an active transfer.
- serial_out  output  1  serial data to detector `check`; idle level 1.
- out_valid  output  1  high while serial_out carries a pattern bit.
- busy  output  1  high in SEND, GAP and DONE.
- done  output  1  one-cycle pulse after the last bit of the last frame.
- bit_index  output  IDX_W  index (0 = first/MSB) of the bit currently on serial_out; 0 when not in SEND.

Behaviour:
- Reset (rst_n=1, async): state=IDLE, serial_out=1, out_valid=0, busy=0, done=0, bit_index=0, internal rep counter=0.
- All outputs are registered and decoded from state/counters. There is no combinational path from inputs to outputs.

State machine:
- IDLE:
  - Outputs: serial_out=1, out_valid=0, busy=0.
  - If start=1 and abort=0 at an edge: latch reps = (repeat_count==0 ? 1 : repeat_count), idx=0, go to SEND.
  - start with abort=1 in the same cycle: stay in IDLE.
- SEND:
  - Outputs: serial_out=PATTERN[PATTERN_W-1-idx], out_valid=1, busy=1, bit_index=idx.
  - idx increments each cycle.
  - At idx=PATTERN_W-1: if reps>1, decrement reps and go to GAP; else go to DONE.
- GAP:
  - Outputs: exactly 1 cycle, serial_out=1, out_valid=0, busy=1.
  - Then idx=0 and go to SEND.
- DONE:
  - Outputs: exactly 1 cycle, done=1, busy=1, serial_out=1, out_valid=0.
  - Then go to IDLE.
- abort=1 in SEND or GAP: next state IDLE, outputs return to idle values on the next cycle, no done pulse. abort in DONE or IDLE has no effect.
- start while busy: ignored, not queued.

Latency and timing:
- First bit appears on serial_out in the cycle after the edge that samples start.
- Transfer length = N*PATTERN_W + (N-1) cycles of serial activity, plus 1 DONE cycle; N = effective repeat count.
- start sampled in the DONE cycle is ignored. A new start is accepted from the first IDLE cycle, so back-to-back transfers have at least 2 idle-high cycles between frames (the DONE cycle plus one IDLE cycle).

Counters:
- idx is IDX_W wide; it never exceeds PATTERN_W-1 and is cleared on entry to SEND.
- reps is REPEAT_W wide, decrements only at end of frame, and never underflows.
- repeat_count changes after the start cycle have no effect.

Mid-transfer reset:
- Async return to reset values in the same cycle as assertion.
- On deassertion the block is in IDLE; the partial frame is not resumed.

Test Plan:
1. Reset, then start=1 for 1 cycle with repeat_count=1 -> serial_out sequence 0,1,1,1,0,0,0,1,1,0,1,1 on 12 consecutive cycles with out_valid=1 and bit_index 0..11, then done=1 for 1 cycle, then serial_out=1, busy=0.
2. repeat_count=3 -> three frames with exactly one serial_out=1, out_valid=0 gap cycle between frames; 38 cycles total from first bit to last bit; single done pulse after the last bit.
3. repeat_count=0 -> behaves identically to repeat_count=1 (12 bits, one done).
4. abort=1 during bit_index=5 of frame 2 of 3 -> next cycle IDLE, serial_out=1, out_valid=0, busy=0, done never asserted; a later start sends a full frame from bit 0.
5. start pulsed during SEND and during the DONE cycle -> ignored, no extra frame. start on the first IDLE cycle after DONE -> new transfer begins on the following cycle.
6. Loopback into the detector with rst_n asserted mid-frame (bit_index=7) -> generator outputs return to reset values asynchronously. After release, start with repeat_count=2 -> detector pattern_detected pulses exactly twice, one cycle after each frame's last bit.

Source files
------------

// File: rtl/moore_seq_generator.sv
// rtl/moore_seq_generator.sv - Serial 12-bit pattern transmitter feeding the Moore sequence detector
//
// Purpose:
//   On a start request, sends PATTERN MSB-first one bit per clock, repeated
//   an effective N times (repeat_count 0 counts as 1). Consecutive frames are
//   separated by one idle-high gap cycle, and a one-cycle done pulse follows
//   the last bit of the last frame. Every output is a flop.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous reset, ACTIVE-HIGH (asserted = 1)
//   start         in   transfer request, honoured only in IDLE
//   repeat_count  in   frames to send, captured together with start
//   abort         in   cancels a transfer in SEND or GAP
//   serial_out    out  serial data, idles at 1
//   out_valid     out  serial_out carries a pattern bit
//   busy          out  high in SEND, GAP and DONE
//   done          out  one-cycle pulse after the final bit
//   bit_index     out  index of the bit on serial_out (0 = MSB), 0 outside SEND

module moore_seq_generator #(
    parameter int                  PATTERN_W = 12,
    parameter logic [PATTERN_W-1:0] PATTERN  = 12'b011100011011,
    parameter int                  REPEAT_W  = 4,
    parameter int                  IDX_W     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [REPEAT_W-1:0] repeat_count,
    input  logic                abort,
    output logic                serial_out,
    output logic                out_valid,
    output logic                busy,
    output logic                done,
    output logic [IDX_W-1:0]    bit_index
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(PATTERN_W - 1);
    localparam logic [REPEAT_W-1:0] ONE_REP  = REPEAT_W'(1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [REPEAT_W-1:0] reps_q, reps_d;
    logic                serial_out_q, serial_out_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [IDX_W-1:0]    bit_index_q, bit_index_d;
    logic [IDX_W-1:0]    bit_sel;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        reps_d  = reps_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    reps_d  = (repeat_count == '0) ? ONE_REP : repeat_count;
                    idx_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (abort) begin
                    idx_d   = '0;
                    reps_d  = '0;
                    state_d = S_IDLE;
                end else if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    // reps counts frames still to send including this one,
                    // so it bottoms out at 1 and never wraps.
                    if (reps_q > ONE_REP) begin
                        reps_d  = reps_q - ONE_REP;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_GAP: begin
                idx_d = '0;
                if (abort) begin
                    reps_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SEND;
                end
            end
            S_DONE: begin
                reps_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                idx_d   = '0;
                reps_d  = '0;
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so that the flops present
        // the bit for a cycle in the same cycle the FSM is in that state.
        bit_sel      = LAST_IDX - idx_d;
        serial_out_d = (state_d == S_SEND) ? PATTERN[bit_sel] : 1'b1;
        out_valid_d  = (state_d == S_SEND);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        bit_index_d  = (state_d == S_SEND) ? idx_d : '0;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            reps_q       <= '0;
            serial_out_q <= 1'b1;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            bit_index_q  <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            reps_q       <= reps_d;
            serial_out_q <= serial_out_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            bit_index_q  <= bit_index_d;
        end
    end

    assign serial_out = serial_out_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign bit_index  = bit_index_q;

endmodule

// File: tb/tb_moore_seq_generator.sv
// tb/tb_moore_seq_generator.sv - Self-checking bench for moore_seq_generator

module tb_moore_seq_generator;

    localparam int PW = 12;
    localparam logic [PW-1:0] PAT = 12'b011100011011;
    localparam logic [7:0] IDLE_OBS = 8'b1000_0000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] repeat_count;
    logic       abort;
    logic       serial_out;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic [3:0] bit_index;

    int checks   = 0;
    int failures = 0;

    // Expected per-cycle observation {serial_out, out_valid, busy, done, bit_index}
    logic [7:0] exp_q[$];

    // Loopback detector: window of the last PW values seen on check
    logic [PW-1:0] win;
    logic          det;

    always #5 clk = ~clk;

    moore_seq_generator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .repeat_count (repeat_count),
        .abort        (abort),
        .serial_out   (serial_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .done         (done),
        .bit_index    (bit_index)
    );

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            win <= '1;
            det <= 1'b0;
        end else begin
            win <= {win[PW-2:0], serial_out};
            det <= ({win[PW-2:0], serial_out} == PAT);
        end
    end

    function automatic logic [7:0] obs();
        return {serial_out, out_valid, busy, done, bit_index};
    endfunction

    // Reference: N frames of pattern bits, one gap between frames, one done cycle.
    task automatic build_expected(input int rc);
        int n;
        logic [PW-1:0] p;
        p = PAT;
        n = (rc == 0) ? 1 : rc;
        exp_q.delete();
        for (int f = 0; f < n; f++) begin
            for (int b = 0; b < PW; b++)
                exp_q.push_back({p[PW-1-b], 1'b1, 1'b1, 1'b0, 4'(b)});
            if (f < n - 1)
                exp_q.push_back(8'b1010_0000);
        end
        exp_q.push_back(8'b1011_0000);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; repeat_count = 4'd0;
        step(); step();
        checks++;
        if (obs() !== IDLE_OBS) begin
            failures++;
            $display("FAIL reset_state got=%b want=%b", obs(), IDLE_OBS);
        end
        rst_n = 1'b0;
        step(); step();
        checks++;
        if (obs() !== IDLE_OBS) begin
            failures++;
            $display("FAIL idle_after_release got=%b want=%b", obs(), IDLE_OBS);
        end
    endtask

    task automatic test_frames(input int rc, input string name, input bit scramble);
        int first_v, last_v, len;
        build_expected(rc);
        len = exp_q.size();
        repeat_count = 4'(rc); start = 1'b1;
        step();
        start = 1'b0;
        first_v = -1; last_v = -1;
        for (int i = 0; i < len; i++) begin
            checks++;
            if (obs() !== exp_q[i]) begin
                failures++;
                $display("FAIL %s cyc=%0d got=%b want=%b", name, i, obs(), exp_q[i]);
            end
            if (out_valid === 1'b1) begin
                if (first_v < 0) first_v = i;
                last_v = i;
            end
            if (scramble) repeat_count = 4'($urandom_range(0, 15));
            step();
        end
        checks++;
        if (obs() !== IDLE_OBS) begin
            failures++;
            $display("FAIL %s_idle_after got=%b want=%b", name, obs(), IDLE_OBS);
        end
        checks++;
        if ((last_v - first_v + 1) != ((rc == 0 ? 1 : rc) * 13 - 1)) begin
            failures++;
            $display("FAIL %s_span got=%0d want=%0d", name, last_v - first_v + 1,
                     (rc == 0 ? 1 : rc) * 13 - 1);
        end
    endtask

    task automatic test_random();
        int rc;
        for (int k = 0; k < 5; k++) begin
            rc = $urandom_range(0, 6);
            test_frames(rc, "random", 1'b1);
            repeat ($urandom_range(0, 3)) step();
        end
    endtask

    task automatic test_abort();
        int done_seen;
        build_expected(3);
        repeat_count = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        // frame 2 bit 5 sits at entry 12 + 1 + 5
        for (int i = 0; i <= 18; i++) begin
            checks++;
            if (obs() !== exp_q[i]) begin
                failures++;
                $display("FAIL abort_pre cyc=%0d got=%b want=%b", i, obs(), exp_q[i]);
            end
            if (i == 18) abort = 1'b1;
            step();
        end
        abort = 1'b0;
        checks++;
        if (obs() !== IDLE_OBS) begin
            failures++;
            $display("FAIL abort_idle got=%b want=%b", obs(), IDLE_OBS);
        end
        done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1 || busy === 1'b1) done_seen++;
            step();
        end
        checks++;
        if (done_seen != 0) begin
            failures++;
            $display("FAIL abort_quiet busy_or_done_cycles=%0d want=0", done_seen);
        end
        test_frames(1, "after_abort", 1'b0);
    endtask

    task automatic test_back_to_back();
        int len;
        build_expected(2);
        len = exp_q.size();
        repeat_count = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < len; i++) begin
            checks++;
            if (obs() !== exp_q[i]) begin
                failures++;
                $display("FAIL b2b cyc=%0d got=%b want=%b", i, obs(), exp_q[i]);
            end
            // pulse in SEND (i=4), in GAP (i=12) and in the DONE cycle (last)
            start = (i == 4 || i == 12 || i == len - 1);
            if (start) repeat_count = 4'd5;
            step();
        end
        // start still high: first IDLE cycle, request is taken here
        repeat_count = 4'd1;
        checks++;
        if (obs() !== IDLE_OBS) begin
            failures++;
            $display("FAIL b2b_idle got=%b want=%b", obs(), IDLE_OBS);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        build_expected(1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs() !== exp_q[i]) begin
                failures++;
                $display("FAIL b2b_next cyc=%0d got=%b want=%b", i, obs(), exp_q[i]);
            end
            step();
        end
        checks++;
        if (obs() !== IDLE_OBS) begin
            failures++;
            $display("FAIL b2b_end got=%b want=%b", obs(), IDLE_OBS);
        end
    endtask

    task automatic test_loopback_reset();
        int  guard, pulses, misplaced;
        logic prev_last;
        repeat_count = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (bit_index !== 4'd7 && guard < 40) begin
            step();
            guard++;
        end
        checks++;
        if (guard >= 40) begin
            failures++;
            $display("FAIL loop_reach_idx7 got=timeout want=bit_index_7");
        end
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if ({obs(), det} !== {IDLE_OBS, 1'b0}) begin
            failures++;
            $display("FAIL async_reset got=%b want=%b", {obs(), det}, {IDLE_OBS, 1'b0});
        end
        @(negedge clk);
        checks++;
        if (obs() !== IDLE_OBS) begin
            failures++;
            $display("FAIL reset_held got=%b want=%b", obs(), IDLE_OBS);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (obs() !== IDLE_OBS) begin
            failures++;
            $display("FAIL no_resume got=%b want=%b", obs(), IDLE_OBS);
        end
        repeat_count = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        pulses = 0; misplaced = 0; prev_last = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (det === 1'b1) begin
                pulses++;
                if (!prev_last) misplaced++;
            end
            prev_last = (out_valid === 1'b1 && bit_index === 4'(PW - 1));
            step();
        end
        checks++;
        if (pulses != 2) begin
            failures++;
            $display("FAIL loop_pulses got=%0d want=2", pulses);
        end
        checks++;
        if (misplaced != 0) begin
            failures++;
            $display("FAIL loop_timing misplaced=%0d want=0", misplaced);
        end
    endtask

    initial begin
        test_reset();
        test_frames(1, "single", 1'b0);
        test_frames(3, "repeat3", 1'b0);
        test_frames(0, "zero", 1'b0);
        test_random();
        test_abort();
        test_back_to_back();
        test_loopback_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
